// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT peak-detect stage.
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_N_2   = 5;
  localparam int FFT_HALF  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } fft_peak_state_t;

  typedef logic [2*FFT_WIDTH-1:0] fft_mag_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined re^2 + im^2 with valid bit and bin tag carried alongside.
module fft_mag_sq #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [2*width-1:0] i_data,
  input  logic [N_2-1:0]     i_bin,
  output logic               o_valid,
  output logic [2*width-1:0] o_mag,
  output logic [N_2-1:0]     o_bin
);

  logic signed [2*width-1:0] w_re_ext;
  logic signed [2*width-1:0] w_im_ext;
  logic        [2*width-1:0] r_re_sq;
  logic        [2*width-1:0] r_im_sq;
  logic                      r_s1_valid;
  logic        [N_2-1:0]     r_s1_bin;

  // Squares never exceed 2^(2w-2), so the low 2w bits of the product are exact.
  assign w_re_ext = {{width{i_data[2*width-1]}}, i_data[2*width-1:width]};
  assign w_im_ext = {{width{i_data[width-1]}}, i_data[width-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
      r_re_sq    <= '0;
      r_im_sq    <= '0;
    end else begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_bin <= i_bin;
        r_re_sq  <= w_re_ext * w_re_ext;
        r_im_sq  <= w_im_ext * w_im_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_bin   <= '0;
      o_mag   <= '0;
    end else begin
      o_valid <= r_s1_valid;
      if (r_s1_valid) begin
        o_bin <= r_s1_bin;
        o_mag <= r_re_sq + r_im_sq;
      end
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Magnitude stream and per-frame peak search over FFT result bins.
// state | meaning: IDLE wait start; SCAN accept bins; DRAIN flush pipe; REPORT pulse result
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int width = FFT_WIDTH,
  parameter int N_2   = FFT_N_2,
  parameter int HALF  = FFT_HALF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [2*width-1:0] in_data,
  output logic               busy,
  output logic               mag_valid,
  output logic [2*width-1:0] mag,
  output logic [N_2-1:0]     mag_bin,
  output logic               peak_valid,
  output logic [N_2-1:0]     peak_bin,
  output logic [2*width-1:0] peak_mag
);

  fft_peak_state_t r_state;
  fft_peak_state_t w_state_nxt;

  logic [N_2-1:0]     r_bin_cnt;
  logic [1:0]         r_drain_cnt;
  logic [2*width-1:0] r_max_mag;
  logic [N_2-1:0]     r_max_bin;
  logic [2*width-1:0] r_peak_mag;
  logic [N_2-1:0]     r_peak_bin;

  logic w_start_acc;
  logic w_accept;
  logic w_last;
  logic w_in_range;
  logic w_report_ld;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_accept    = (r_state == SCAN) && in_valid;
  assign w_last      = w_accept && (&r_bin_cnt);
  assign w_in_range  = (HALF == 0) || (mag_bin[N_2-1] == 1'b0);
  assign w_report_ld = (r_state == DRAIN) && (w_state_nxt == REPORT);

  fft_mag_sq #(
    .width (width),
    .N_2   (N_2)
  ) u_mag_sq (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_accept),
    .i_data  (in_data),
    .i_bin   (r_bin_cnt),
    .o_valid (mag_valid),
    .o_mag   (mag),
    .o_bin   (mag_bin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SCAN;
      SCAN:    if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain_cnt == 2'd0) w_state_nxt = REPORT;
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy       = (r_state == SCAN) || (r_state == DRAIN);
  assign peak_valid = (r_state == REPORT);
  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;

  // Drain timer spans the two pipeline stages plus the running-max update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_start_acc)   r_bin_cnt <= '0;
      else if (w_accept) r_bin_cnt <= r_bin_cnt + 1'b1;

      if (w_last)                                        r_drain_cnt <= 2'd2;
      else if ((r_state == DRAIN) && (r_drain_cnt != 0)) r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Strict greater-than keeps the lowest bin on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_max_mag  <= '0;
      r_max_bin  <= '0;
      r_peak_mag <= '0;
      r_peak_bin <= '0;
    end else begin
      if (w_start_acc) begin
        r_max_mag <= '0;
        r_max_bin <= '0;
      end else if (mag_valid && w_in_range && (mag > r_max_mag)) begin
        r_max_mag <= mag;
        r_max_bin <= mag_bin;
      end

      if (w_start_acc) begin
        r_peak_mag <= '0;
        r_peak_bin <= '0;
      end else if (w_report_ld) begin
        r_peak_mag <= r_max_mag;
        r_peak_bin <= r_max_bin;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomized and directed bench for fft_peak_detect against a frame-level model.
module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int W     = 16;
  localparam int NB    = 5;
  localparam int N     = 32;
  localparam int HALFP = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [2*W-1:0] in_data;
  logic          busy;
  logic          mag_valid;
  fft_mag_t      mag;
  logic [NB-1:0] mag_bin;
  logic          peak_valid;
  logic [NB-1:0] peak_bin;
  fft_mag_t      peak_mag;

  int n_checks = 0;
  int n_errors = 0;
  int mag_cnt  = 0;

  longint exp_q[$];
  int     exp_bin_q[$];

  logic signed [W-1:0] f_re[N];
  logic signed [W-1:0] f_im[N];

  longint last_pmag;
  int     last_pbin;

  fft_peak_detect #(.width(W), .N_2(NB), .HALF(HALFP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .busy       (busy),
    .mag_valid  (mag_valid),
    .mag        (mag),
    .mag_bin    (mag_bin),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sq_mag(input int b);
    longint re;
    longint im;
    re = f_re[b];
    im = f_im[b];
    return re * re + im * im;
  endfunction

  always @(negedge clk) begin : mon
    longint e;
    int     eb;
    if (!reset && mag_valid) begin
      mag_cnt++;
      if (exp_q.size() == 0) begin
        chk("mag_spurious", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        eb = exp_bin_q.pop_front();
        chk("mag", mag, e);
        chk("mag_bin", mag_bin, eb);
      end
    end
  end

  task automatic clear_frame();
    for (int b = 0; b < N; b++) begin
      f_re[b] = '0;
      f_im[b] = '0;
    end
  endtask

  task automatic rand_frame();
    for (int b = 0; b < N; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        f_re[b] = '0;
        f_im[b] = '0;
      end else begin
        f_re[b] = W'($urandom);
        f_im[b] = W'($urandom);
      end
    end
  endtask

  task automatic drive_bin(input int b);
    in_valid = 1'b1;
    in_data  = {f_re[b], f_im[b]};
    exp_q.push_back(sq_mag(b));
    exp_bin_q.push_back(b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom) << W;
  endtask

  // gap_mode: 0 gapless, 1 alternating bubbles, 2 random bubbles
  task automatic run_frame(input int gap_mode, input string tag);
    int     m0;
    int     c;
    int     lim;
    int     pb;
    longint pm;
    bit     seen;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_peak_bin_clr"}, peak_bin, 0);
    chk({tag, "_peak_mag_clr"}, peak_mag, 0);
    m0 = mag_cnt;
    for (int b = 0; b < N; b++) begin
      drive_bin(b);
      if (b < N - 1) begin
        if (gap_mode == 1) begin
          @(posedge clk); #1;
        end else if (gap_mode == 2) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
      end
    end
    pm  = 0;
    pb  = 0;
    lim = (HALFP != 0) ? N / 2 : N;
    for (int b = 0; b < lim; b++) begin
      if (sq_mag(b) > pm) begin
        pm = sq_mag(b);
        pb = b;
      end
    end
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 12) begin
      @(negedge clk);
      c++;
      if (peak_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_peak_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_peak_latency"}, c, 4);
    chk({tag, "_peak_bin"}, peak_bin, pb);
    chk({tag, "_peak_mag"}, peak_mag, pm);
    chk({tag, "_busy_at_peak"}, busy, 0);
    chk({tag, "_mag_count"}, mag_cnt - m0, N);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    last_pbin = peak_bin;
    last_pmag = peak_mag;
    @(posedge clk);
    #1;
    chk({tag, "_peak_pulse"}, peak_valid, 0);
    chk({tag, "_peak_hold"}, peak_bin, pb);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mag_valid"}, mag_valid, 0);
    chk({tag, "_mag"}, mag, 0);
    chk({tag, "_mag_bin"}, mag_bin, 0);
    chk({tag, "_peak_valid"}, peak_valid, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_mag"}, peak_mag, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     gb;
    longint gm;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    in_valid = 1'b1;
    in_data  = {16'sd1234, 16'sd777};
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("idle_ignore_busy", busy, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    clear_frame();
    f_re[5] = 16'sd300;
    f_im[5] = -16'sd400;
    run_frame(0, "tone");
    chk("tone_bin", last_pbin, 5);
    chk("tone_mag", last_pmag, 250000);

    clear_frame();
    f_re[3] = 16'sd100;
    f_re[7] = 16'sd100;
    run_frame(0, "tie");
    chk("tie_bin", last_pbin, 3);
    chk("tie_mag", last_pmag, 10000);

    clear_frame();
    f_re[9] = 16'sh8000;
    f_im[9] = 16'sh8000;
    run_frame(0, "extreme");
    chk("extreme_bin", last_pbin, 9);
    chk("extreme_mag", last_pmag, 64'h8000_0000);

    clear_frame();
    f_re[20] = 16'sd1000;
    f_re[2]  = 16'sd10;
    run_frame(0, "half");
    chk("half_bin", last_pbin, 2);
    chk("half_mag", last_pmag, 100);

    clear_frame();
    run_frame(0, "zero");
    chk("zero_bin", last_pbin, 0);
    chk("zero_mag", last_pmag, 0);

    rand_frame();
    run_frame(0, "gapless");
    gb = last_pbin;
    gm = last_pmag;
    run_frame(1, "bubble1");
    chk("bubble1_same_bin", last_pbin, gb);
    chk("bubble1_same_mag", last_pmag, gm);
    run_frame(1, "bubble2");
    chk("bubble2_same_bin", last_pbin, gb);
    chk("bubble2_same_mag", last_pmag, gm);

    repeat (6) begin
      rand_frame();
      run_frame(2, "rand");
    end

    rand_frame();
    f_re[0] = 16'sd500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 10; b++) drive_bin(b);
    in_valid = 1'b1;
    in_data  = {f_re[10], f_im[10]};
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    in_valid = 1'b0;
    exp_q.delete();
    exp_bin_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_idle", busy, 0);
    run_frame(0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
